push_button_debounce: RTL

- Receiving end of the push-button stimulus that the clock benches drive onto i_push_button.
- Synchronises the raw asynchronous button input into the clk_5MHz domain and debounces it.
- Emits a clean level plus single-cycle press, release, long-press and optional auto-repeat events.
- The time-setting logic of the digital clock consumes these events.

---
 rtl/push_button_debounce.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/push_button_debounce.sv
// Two-flop synchroniser and debounce FSM for the time-setting push button.
// Auto-repeat pulses on o_repeat are built only when PUSH_BUTTON_AUTO_REPEAT_EN is defined.
module push_button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES   = 100000,
  parameter int unsigned LONG_PRESS_CYCLES = 5000000,
  parameter int unsigned REPEAT_CYCLES     = 1000000
) (
  input  logic clk_5MHz,
  input  logic i_rst_n,
  input  logic i_push_button,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat
);

  localparam int unsigned MAX_DL = (DEBOUNCE_CYCLES > LONG_PRESS_CYCLES) ?
                                   DEBOUNCE_CYCLES : LONG_PRESS_CYCLES;
`ifdef PUSH_BUTTON_AUTO_REPEAT_EN
  localparam int unsigned MAX_CYC = (REPEAT_CYCLES > MAX_DL) ? REPEAT_CYCLES : MAX_DL;
`else
  localparam int unsigned MAX_CYC = MAX_DL;
`endif
  localparam int unsigned CW = $clog2(MAX_CYC + 32'd1);

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] DB_LIM   = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LONG_LIM = CW'(LONG_PRESS_CYCLES);
  localparam logic [CW-1:0] LONG_THR = CW'(LONG_PRESS_CYCLES - 32'd1);
`ifdef PUSH_BUTTON_AUTO_REPEAT_EN
  localparam logic [CW-1:0] REP_LIM  = CW'(REPEAT_CYCLES);
  localparam logic [CW-1:0] REP_THR  = CW'(REPEAT_CYCLES - 32'd1);
`endif

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    LONG     = 2'd3
  } state_t;

  // Counters stop at their limit instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic [CW-1:0] lim);
    logic [CW-1:0] r;
    if (v >= lim) begin
      r = lim;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  logic          sync1_q, sync2_q;
  state_t        state_q, state_d;
  logic [CW-1:0] db_cnt_q, db_cnt_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic [CW-1:0] rel_cnt_q, rel_cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;
`ifdef PUSH_BUTTON_AUTO_REPEAT_EN
  logic [CW-1:0] rep_cnt_q, rep_cnt_d;
  logic          repeat_q, repeat_d;
`endif

  // The raw button is asynchronous; only sync2_q is seen by the FSM.
  always_ff @(posedge clk_5MHz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= i_push_button;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk_5MHz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      db_cnt_q   <= CNT_ZERO;
      hold_cnt_q <= CNT_ZERO;
      rel_cnt_q  <= CNT_ZERO;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      rel_cnt_q  <= rel_cnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
    end
  end

`ifdef PUSH_BUTTON_AUTO_REPEAT_EN
  always_ff @(posedge clk_5MHz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rep_cnt_q <= CNT_ZERO;
      repeat_q  <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      repeat_q  <= repeat_d;
    end
  end
`endif

  // Release completion is checked before the long/repeat thresholds so it always wins.
  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    rel_cnt_d  = rel_cnt_q;
    level_d    = level_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
`ifdef PUSH_BUTTON_AUTO_REPEAT_EN
    rep_cnt_d  = rep_cnt_q;
    repeat_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        level_d    = 1'b0;
        hold_cnt_d = CNT_ZERO;
        rel_cnt_d  = CNT_ZERO;
        if (sync2_q) begin
          state_d  = PRESS_DB;
          db_cnt_d = CNT_ONE;
        end else begin
          state_d  = IDLE;
          db_cnt_d = CNT_ZERO;
        end
      end
      PRESS_DB: begin
        if (!sync2_q) begin
          state_d  = IDLE;
          db_cnt_d = CNT_ZERO;
        end else if (db_cnt_q >= DB_LIM) begin
          state_d    = HELD;
          db_cnt_d   = CNT_ZERO;
          hold_cnt_d = CNT_ZERO;
          rel_cnt_d  = CNT_ZERO;
          level_d    = 1'b1;
          press_d    = 1'b1;
        end else begin
          db_cnt_d = sat_inc(db_cnt_q, DB_LIM);
        end
      end
      HELD: begin
        hold_cnt_d = sat_inc(hold_cnt_q, LONG_LIM);
        rel_cnt_d  = sync2_q ? CNT_ZERO : sat_inc(rel_cnt_q, DB_LIM);
        if (!sync2_q && (rel_cnt_q >= DB_LIM)) begin
          state_d    = IDLE;
          level_d    = 1'b0;
          release_d  = 1'b1;
          hold_cnt_d = CNT_ZERO;
          rel_cnt_d  = CNT_ZERO;
        end else if (hold_cnt_q >= LONG_THR) begin
          state_d = LONG;
          long_d  = 1'b1;
`ifdef PUSH_BUTTON_AUTO_REPEAT_EN
          rep_cnt_d = CNT_ZERO;
          repeat_d  = 1'b1;
`endif
        end else begin
          state_d = HELD;
        end
      end
      LONG: begin
        rel_cnt_d = sync2_q ? CNT_ZERO : sat_inc(rel_cnt_q, DB_LIM);
        if (!sync2_q && (rel_cnt_q >= DB_LIM)) begin
          state_d    = IDLE;
          level_d    = 1'b0;
          release_d  = 1'b1;
          hold_cnt_d = CNT_ZERO;
          rel_cnt_d  = CNT_ZERO;
        end else begin
          state_d = LONG;
`ifdef PUSH_BUTTON_AUTO_REPEAT_EN
          if (rep_cnt_q >= REP_THR) begin
            rep_cnt_d = CNT_ZERO;
            repeat_d  = 1'b1;
          end else begin
            rep_cnt_d = sat_inc(rep_cnt_q, REP_LIM);
          end
`endif
        end
      end
      default: begin
        state_d    = IDLE;
        db_cnt_d   = CNT_ZERO;
        hold_cnt_d = CNT_ZERO;
        rel_cnt_d  = CNT_ZERO;
        level_d    = 1'b0;
      end
    endcase
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_long    = long_q;
`ifdef PUSH_BUTTON_AUTO_REPEAT_EN
  assign o_repeat  = repeat_q;
`else
  assign o_repeat  = 1'b0 && (REPEAT_CYCLES != 32'd0);
`endif

endmodule
